// File: rtl/clock_hhmm.sv
// Hours:minutes BCD time-of-day counter driven by the minute divider, with a
// mode/increment set-time state machine. All outputs come straight from flops.

module clock_hhmm_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              pulse_q;

  // Registered rising-edge strobe; the reset value of prev_q matches the
  // chain so reset release never fakes an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= {STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], d_i};
      prev_q  <= sync_q[STAGES-1];
      pulse_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;
endmodule

module clock_hhmm #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clk60s_i,
  input  logic       mode_i,
  input  logic       inc_i,
  output logic [3:0] min_u_o,
  output logic [2:0] min_t_o,
  output logic [3:0] hr_u_o,
  output logic [1:0] hr_t_o,
  output logic [1:0] set_o,
  output logic       day_o
);
  localparam int NUM_IN = 3;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_e;

  typedef struct packed {
    logic [1:0] ht;
    logic [3:0] hu;
    logic [2:0] mt;
    logic [3:0] mu;
  } tod_t;

  logic [NUM_IN-1:0] raw, strb;
  logic              tick, mode_p, inc_p;

  assign raw = {inc_i, mode_i, clk60s_i};

  // Lane 0 (minute divider) idles high, so its chain resets to 1.
  for (genvar g = 0; g < NUM_IN; g++) begin : g_sync
    clock_hhmm_sync #(
      .STAGES (SYNC_STAGES),
      .RST_VAL((g == 0) ? 1'b1 : 1'b0)
    ) u_sync (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (raw[g]),
      .pulse_o(strb[g])
    );
  end

  assign tick   = strb[0];
  assign mode_p = strb[1];
  assign inc_p  = strb[2];

  function automatic tod_t inc_min(input tod_t t);
    tod_t r;
    r = t;
    if (t.mu == 4'd9) begin
      r.mu = 4'd0;
      r.mt = (t.mt == 3'd5) ? 3'd0 : t.mt + 3'd1;
    end else begin
      r.mu = t.mu + 4'd1;
    end
    return r;
  endfunction

  function automatic tod_t inc_hr(input tod_t t);
    tod_t r;
    r = t;
    if (t.ht == 2'd2 && t.hu == 4'd3) begin
      r.ht = 2'd0;
      r.hu = 4'd0;
    end else if (t.hu == 4'd9) begin
      r.hu = 4'd0;
      r.ht = t.ht + 2'd1;
    end else begin
      r.hu = t.hu + 4'd1;
    end
    return r;
  endfunction

  state_e state_q, state_d;
  tod_t   tod_q, tod_d;
  logic   day_q, day_d;
  logic   min_wrap;

  assign min_wrap = (tod_q.mt == 3'd5) && (tod_q.mu == 4'd9);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      tod_q   <= '0;
      day_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tod_q   <= tod_d;
      day_q   <= day_d;
    end
  end

  // mode_p has priority: a coincident tick or inc is dropped.
  always_comb begin
    state_d = state_q;
    tod_d   = tod_q;
    day_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (mode_p) begin
          state_d = SET_HR;
        end else if (tick) begin
          tod_d = inc_min(tod_q);
          if (min_wrap) begin
            tod_d = inc_hr(tod_d);
            day_d = (tod_q.ht == 2'd2) && (tod_q.hu == 4'd3);
          end
        end
      end
      SET_HR: begin
        if (mode_p)     state_d = SET_MIN;
        else if (inc_p) tod_d   = inc_hr(tod_q);
      end
      SET_MIN: begin
        if (mode_p)     state_d = RUN;
        else if (inc_p) tod_d   = inc_min(tod_q);
      end
      default: state_d = RUN;
    endcase
  end

  assign min_u_o = tod_q.mu;
  assign min_t_o = tod_q.mt;
  assign hr_u_o  = tod_q.hu;
  assign hr_t_o  = tod_q.ht;
  assign set_o   = state_q;
  assign day_o   = day_q;
endmodule

// File: tb/tb_clock_hhmm.sv
// Randomized scoreboard bench for clock_hhmm: a minutes-of-day model predicts
// each input event's result, a negedge monitor checks it at its due cycle.
module tb_clock_hhmm;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       clk60s_i = 1'b1;
  logic       mode_i = 1'b0;
  logic       inc_i = 1'b0;
  wire  [3:0] min_u_o;
  wire  [2:0] min_t_o;
  wire  [3:0] hr_u_o;
  wire  [1:0] hr_t_o;
  wire  [1:0] set_o;
  wire        day_o;

  clock_hhmm #(.SYNC_STAGES(SYNC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk60s_i(clk60s_i), .mode_i(mode_i),
    .inc_i(inc_i), .min_u_o(min_u_o), .min_t_o(min_t_o), .hr_u_o(hr_u_o),
    .hr_t_o(hr_t_o), .set_o(set_o), .day_o(day_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int        due;
    logic [14:0] val;
    string     tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: minutes since midnight and a 0/1/2 mode index.
  int   m_tod = 0;
  int   m_st  = 0;
  logic m_day = 1'b0;

  function automatic logic [14:0] pack_exp(input int tod, input int st, input logic day);
    int h, m;
    logic [1:0] ht; logic [3:0] hu; logic [2:0] mt; logic [3:0] mu; logic [1:0] s;
    h = tod / 60; m = tod % 60;
    ht = 2'(h / 10); hu = 4'(h % 10); mt = 3'(m / 10); mu = 4'(m % 10); s = 2'(st);
    return {ht, hu, mt, mu, s, day};
  endfunction

  wire [14:0] dut_val = {hr_t_o, hr_u_o, min_t_o, min_u_o, set_o, day_o};

  always @(negedge clk_i) begin
    if (!rst_i) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        if (e.due != cyc || dut_val !== e.val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d (due %0d): got %h, expected %h", e.tag, cyc, e.due,
                   dut_val, e.val);
        end
      end
    end
  end

  function automatic void model_step(input bit tk, input bit md, input bit ic);
    int h, m;
    h = m_tod / 60; m = m_tod % 60;
    m_day = 1'b0;
    if (md) begin
      m_st = (m_st + 1) % 3;
    end else if (m_st == 0 && tk) begin
      m_tod = (m_tod + 1) % 1440;
      m_day = (m_tod == 0);
    end else if (m_st == 1 && ic) begin
      m_tod = ((h + 1) % 24) * 60 + m;
    end else if (m_st == 2 && ic) begin
      m_tod = h * 60 + (m + 1) % 60;
    end
  endfunction

  // One input event: raise any mix of clk60s/mode/inc together, hold, release.
  task automatic ev(input bit tk, input bit md, input bit ic, input int hold, input string tag);
    exp_t e;
    if (tk) begin
      clk60s_i = 1'b0;
      repeat (4) @(posedge clk_i);
    end
    @(posedge clk_i); #1;
    if (tk) clk60s_i = 1'b1;
    if (md) mode_i = 1'b1;
    if (ic) inc_i = 1'b1;
    model_step(tk, md, ic);
    e.due = cyc + LAT;     e.val = pack_exp(m_tod, m_st, m_day); e.tag = tag; q.push_back(e);
    e.due = cyc + LAT + 1; e.val = pack_exp(m_tod, m_st, 1'b0);  e.tag = {tag, "_next"}; q.push_back(e);
    repeat (hold) @(posedge clk_i);
    #1; mode_i = 1'b0; inc_i = 1'b0;
    repeat (6) @(posedge clk_i);
  endtask

  task automatic set_time(input int h, input int m);
    int nh, nm;
    ev(0, 1, 0, 4, "to_set_hr");
    nh = (h - m_tod / 60 + 24) % 24;
    for (int i = 0; i < nh; i++) ev(0, 0, 1, 4, "set_hr_inc");
    ev(0, 1, 0, 4, "to_set_min");
    nm = (m - m_tod % 60 + 60) % 60;
    for (int i = 0; i < nm; i++) ev(0, 0, 1, 4, "set_min_inc");
    ev(0, 1, 0, 4, "to_run");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(posedge clk_i);
      n++;
    end
    if (q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_now(input string tag, input logic [14:0] want);
    n_cmp++;
    if (dut_val !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, dut_val, want);
    end
  endtask

  initial begin
    exp_t e;
    int r;
    repeat (3) @(posedge clk_i);
    #1;
    check_now("reset_state", 15'd0);
    rst_i = 1'b0;
    e.due = cyc + 6; e.val = pack_exp(0, 0, 1'b0); e.tag = "no_false_tick"; q.push_back(e);
    drain();

    for (int i = 0; i < 60; i++) ev(1, 0, 0, 4, "run_tick");

    set_time(22, 0);
    ev(0, 1, 0, 4, "mode_set_hr");
    for (int i = 0; i < 5; i++) ev(0, 0, 1, 4, "hr_inc");
    ev(0, 1, 0, 4, "mode_set_min");
    for (int i = 0; i < 61; i++) ev(0, 0, 1, 4, "min_inc");
    ev(0, 1, 0, 4, "mode_run");

    ev(0, 1, 0, 4, "frz_mode");
    for (int i = 0; i < 10; i++) ev(1, 0, 0, 4, "frozen_tick");
    ev(0, 1, 0, 4, "frz_mode2");
    ev(0, 0, 1, 100, "held_inc");
    ev(0, 1, 0, 4, "frz_run");
    ev(1, 0, 0, 4, "after_frozen_tick");

    ev(0, 1, 0, 4, "col_mode");
    ev(0, 1, 1, 4, "col_mode_inc");
    ev(0, 1, 0, 4, "col_mode_run");
    ev(1, 1, 0, 4, "col_tick_mode");
    ev(0, 1, 0, 4, "col_m2");
    ev(0, 1, 0, 4, "col_m3");

    set_time(23, 59);
    ev(1, 0, 0, 4, "day_rollover");

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      ev(r < 5 || r == 8, r == 5 || r == 8, r >= 6, $urandom_range(2, 8), "random");
    end
    if (m_st != 0) begin
      for (int i = m_st; i < 3; i++) ev(0, 1, 0, 4, "rnd_to_run");
    end

    set_time(12, 34);
    drain();
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    #1;
    check_now("async_reset", 15'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    m_tod = 0; m_st = 0; m_day = 1'b0;
    e.due = cyc + 6; e.val = pack_exp(0, 0, 1'b0); e.tag = "post_reset_idle"; q.push_back(e);
    drain();
    ev(1, 0, 0, 4, "post_reset_tick");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clock_hhmm.md
# clock_hhmm

Time-of-day counter downstream of the 1/60 Hz minute divider. Samples the divider's registered `clk60s_o` as a slow data input on the block's own clock, turns each rising edge into a one-cycle minute tick and keeps hours:minutes in BCD (00:00–23:59) for the display driver. Two debounced buttons, mode and increment, give a three-state set-time state machine.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops in each input synchronizer. Legal values are 2 to 4.

Ports:
- `clk_i`  in  1  block clock; free-running, at least 4× faster than any input transition.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `clk60s_i`  in  1  minute divider output; each rising edge is one minute.
- `mode_i`  in  1  debounced mode button, level-high while pressed.
- `inc_i`  in  1  debounced increment button, level-high while pressed.
- `min_u_o`  out  4  minutes units BCD, 0–9.
- `min_t_o`  out  3  minutes tens BCD, 0–5.
- `hr_u_o`  out  4  hours units BCD, 0–9; 0–3 when `hr_t_o`=2.
- `hr_t_o`  out  2  hours tens BCD, 0–2.
- `set_o`  out  2  state: 00 RUN, 01 SET_HR, 10 SET_MIN.
- `day_o`  out  1  one-cycle pulse on the 23:59→00:00 rollover in RUN.

One clock (`clk_i`). Reset is asynchronous and active-high (`rst_i`). All flops reset asynchronously; all outputs are registered.

## Operation
- Synchronizers: `clk60s_i`, `mode_i` and `inc_i` each pass through `SYNC_STAGES` flops, then one edge-detect flop.
  - The `clk60s_i` chain resets to 1, matching the divider's reset value of 1, so reset release produces no false tick.
  - The button chains reset to 0.
- Internal one-cycle strobes: `tick` (clk60s rising edge), `mode_p` (mode rising edge), `inc_p` (inc rising edge). Falling edges are ignored. A held button gives exactly one strobe.
- State machine:
  - RUN + `mode_p` → SET_HR.
  - SET_HR + `mode_p` → SET_MIN.
  - SET_MIN + `mode_p` → RUN.
  - Any other combination stays in the current state. State 11 is unreachable; if entered, go to RUN on the next cycle.
- RUN:
  - `tick` increments minutes: units 9→0 with tens+1; 59→00 with carry to hours.
  - Hours increment: units 9→0 with tens+1; 23→00.
  - `inc_p` is ignored.
- SET_HR: `tick` is ignored (time frozen). `inc_p` increments hours modulo 24, with no effect on minutes.
- SET_MIN: `tick` is ignored. `inc_p` increments minutes modulo 60, with no carry into hours.
- Priority in one cycle: `mode_p` wins. A coincident `inc_p` or `tick` is dropped and the state advances.
- `day_o` is asserted only for a RUN `tick` at 23:59. A manual wrap in a set state never pulses it.
- BCD digits never hold illegal codes. Every increment is computed per digit; there is no binary-to-BCD conversion.

## Timing
- Reset values: time 00:00 (all digit outputs 0), `set_o`=00, `day_o`=0.
- Input to strobe: an input edge appears as a strobe SYNC_STAGES+1 cycles later (3 at default).
- Strobe to output: digits and `set_o` update on the clock edge after the strobe. Total input-edge-to-output latency is SYNC_STAGES+2 cycles.
- `day_o` is high in the same cycle the digits first read 00:00.
- Minimum spacing: inputs must stay stable for 2 clk_i cycles between edges. Closer edges may be lost and are not required to count.
- Reset asserted mid-operation clears everything immediately, with no clock required. The first tick after release needs a full low→high transition of `clk60s_i`.

## Test plan
- Reset then run: hold `clk60s_i`=1 through reset release; no tick, outputs stay 00:00. Drive 60 rising edges; reads 01:00, and each update lands exactly 4 cycles after its edge at default sync.
- Day rollover: set 23:59 through the buttons, return to RUN, apply 1 edge; reads 00:00 with `day_o` high for exactly 1 cycle.
- Set mode: mode press → `set_o`=01; 5 inc presses from 22 → 03; mode → 10; 61 inc presses from 00 → 01 with hours unchanged at 03; mode → 00.
- Frozen time: in SET_HR apply 10 `clk60s_i` edges; minutes unchanged. Back in RUN the next edge increments.
- Collisions: `mode_p` and `inc_p` in the same cycle in SET_HR; state advances and hours are unchanged. `tick` coincident with `mode_p` in RUN; state → SET_HR and minutes unchanged.
- Held button and mid-run reset: hold inc high for 100 cycles in SET_MIN; exactly +1. Pulse `rst_i` at 12:34 between clock edges; outputs read 00:00 before the next `clk_i` edge.
